// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: single-outstanding valid/ready front end for a 32-bit SRAM.
// Drives cs one cycle ahead of oe/we so address and data are settled first,
// holds the strobe for ACCESS_CYCLES cycles and returns a one-cycle response.
// All outputs come straight from flops.
// Optional feature macro: SRAM_PORT_CTRL_ALIGN_CHECK_EN (reject misaligned
// addresses with resp_err instead of touching the SRAM).
module sram_port_ctrl #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_sram_cs,
  output logic        o_sram_oe,
  output logic        o_sram_we,
  output logic [31:0] o_sram_addr,
  output logic [31:0] o_sram_din,
  input  logic [31:0] i_sram_dout
);

  localparam logic [3:0] LP_LAST_CNT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_we;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [31:0] w_rdata_nxt;
  logic        r_resp_err;
  logic        r_sram_cs;
  logic        r_sram_oe;
  logic        r_sram_we;
  logic [31:0] r_sram_addr;
  logic [31:0] r_sram_din;
  logic        w_accept;
  logic        w_misalign;
  logic        w_reject;

  // ready is only ever high in IDLE, so this is the acceptance condition
  assign w_accept = i_req_valid & r_req_ready;

`ifdef SRAM_PORT_CTRL_ALIGN_CHECK_EN
  assign w_misalign = (i_req_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Next-state, wait counter, rejection and response-data selection
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misalign) begin
            w_state_nxt = ST_DONE;
            w_reject    = 1'b1;
          end else begin
            w_state_nxt = ST_SETUP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
        w_cnt_nxt   = 4'd0;
      end
      ST_ACCESS: begin
        if (r_cnt == LP_LAST_CNT) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    // read data is captured on the edge ending the last strobe cycle
    if ((r_state == ST_ACCESS) && (w_state_nxt == ST_DONE)) begin
      w_rdata_nxt = r_we ? 32'h0000_0000 : i_sram_dout;
    end else if (w_reject) begin
      w_rdata_nxt = 32'h0000_0000;
    end else begin
      w_rdata_nxt = r_resp_rdata;
    end
  end

  // State register plus registered outputs decoded from the next state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_resp_err   <= 1'b0;
      r_sram_cs    <= 1'b0;
      r_sram_oe    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= 32'h0000_0000;
      r_sram_din   <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= (w_state_nxt == ST_IDLE);
      r_resp_valid <= (w_state_nxt == ST_DONE);
      r_resp_err   <= w_reject;
      r_resp_rdata <= w_rdata_nxt;
      // ACCESS is only reachable through SETUP, so r_we is already latched
      r_sram_cs    <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
      r_sram_oe    <= (w_state_nxt == ST_ACCESS) && !r_we;
      r_sram_we    <= (w_state_nxt == ST_ACCESS) && r_we;
      if (w_accept) begin
        r_we <= i_req_we;
        if (!w_misalign) begin
          r_sram_addr <= i_req_addr;
          r_sram_din  <= i_req_wdata;
        end else begin
          r_sram_addr <= r_sram_addr;
          r_sram_din  <= r_sram_din;
        end
      end else begin
        r_we <= r_we;
      end
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_sram_cs    = r_sram_cs;
  assign o_sram_oe    = r_sram_oe;
  assign o_sram_we    = r_sram_we;
  assign o_sram_addr  = r_sram_addr;
  assign o_sram_din   = r_sram_din;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural SRAM, table of directed transactions,
// hand-written multi-cycle sequences and randomized traffic against a
// transaction-level reference model.
module tb_sram_port_ctrl;
  localparam int N   = 4;
  localparam int LAT = 2 + N;

`ifdef SRAM_PORT_CTRL_ALIGN_CHECK_EN
  localparam logic        MIS_ERR = 1'b1;
  localparam int          MIS_LAT = 1;
  localparam logic [31:0] V7_RD   = 32'h0000_0000;
  localparam logic [31:0] V9_RD   = 32'hDEAD_BEEF;
`else
  localparam logic        MIS_ERR = 1'b0;
  localparam int          MIS_LAT = LAT;
  localparam logic [31:0] V7_RD   = 32'hDEAD_BEEF;
  localparam logic [31:0] V9_RD   = 32'h0000_0055;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        sram_cs, sram_oe, sram_we;
  logic [31:0] sram_addr, sram_din, sram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_port_ctrl #(.ACCESS_CYCLES(N)) u_dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_sram_cs(sram_cs), .o_sram_oe(sram_oe), .o_sram_we(sram_we),
    .o_sram_addr(sram_addr), .o_sram_din(sram_din), .i_sram_dout(sram_dout)
  );

  // Behavioural SRAM: combinational read, write on clock edge, backdoor port
  logic [31:0] sram_mem [0:1023];
  logic        bd_en = 1'b0;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;
  assign sram_dout = (sram_cs && sram_oe) ? sram_mem[sram_addr[11:2]] : 32'h0000_0000;
  always @(posedge clk) begin
    if (bd_en) sram_mem[bd_idx] <= bd_data;
    else if (sram_cs && sram_we) sram_mem[sram_addr[11:2]] <= sram_din;
  end

  // Reference memory, keyed by word address
  logic [31:0] ref_mem [int unsigned];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [31:0] addr, input logic [31:0] data);
    bd_en = 1'b1; bd_idx = addr[11:2]; bd_data = data;
    step();
    bd_en = 1'b0;
  endtask

  // Reference model: response of one transaction from the access rules
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output int lat);
    logic rej;
`ifdef SRAM_PORT_CTRL_ALIGN_CHECK_EN
    rej = (addr[1:0] != 2'b00);
`else
    rej = 1'b0;
`endif
    if (rej) begin
      rd = 32'h0; err = 1'b1; lat = 1;
    end else begin
      err = 1'b0; lat = LAT;
      if (we) begin
        ref_mem[addr >> 2] = wdata;
        rd = 32'h0;
      end else begin
        rd = ref_mem.exists(addr >> 2) ? ref_mem[addr >> 2] : 32'h0;
      end
    end
  endtask

  // One complete transaction with latency, strobe-count and response checks
  task automatic do_txn(input string nm, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat);
    int lat, cs_c, oe_c, we_c, wait_c;
    logic busy_bad;
    logic [31:0] addr_before, din_before;
    addr_before = sram_addr; din_before = sram_din;
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    wait_c = 0;
    while (!req_ready && wait_c < 50) begin step(); wait_c++; end
    chk({nm, "_ready_before"}, {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    if (exp_err) begin
      chk({nm, "_addr_kept"}, sram_addr, addr_before);
      chk({nm, "_din_kept"}, sram_din, din_before);
    end else begin
      chk({nm, "_addr"}, sram_addr, addr);
      chk({nm, "_din"}, sram_din, wdata);
    end
    lat = 1; cs_c = 0; oe_c = 0; we_c = 0; busy_bad = 1'b0;
    while (!resp_valid && lat < 40) begin
      cs_c += int'(sram_cs); oe_c += int'(sram_oe); we_c += int'(sram_we);
      if (req_ready) busy_bad = 1'b1;
      step(); lat++;
    end
    chk({nm, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_rdata"}, resp_rdata, exp_rd);
    chk({nm, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
    chk({nm, "_busy_ready"}, {31'b0, busy_bad | req_ready}, 32'd0);
    chk({nm, "_cs_cycles"}, cs_c, exp_err ? 0 : N + 1);
    chk({nm, "_oe_cycles"}, oe_c, (exp_err || we) ? 0 : N);
    chk({nm, "_we_cycles"}, we_c, (exp_err || !we) ? 0 : N);
    step();
    chk({nm, "_pulse_width"}, {31'b0, resp_valid}, 32'd0);
    chk({nm, "_ready_after"}, {31'b0, req_ready}, 32'd1);
    chk({nm, "_rdata_hold"}, resp_rdata, exp_rd);
  endtask

  // Strobe-ordering monitor: cs leads oe/we, addr/din frozen while cs high
  initial begin
    logic p_cs, p_oe, p_we;
    logic [31:0] p_addr, p_din;
    p_cs = 1'b0; p_oe = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_din = 32'h0;
    forever begin
      step();
      if (sram_cs && p_cs) begin
        chk("mon_addr_stable", sram_addr, p_addr);
        chk("mon_din_stable", sram_din, p_din);
      end
      if ((sram_oe && !p_oe) || (sram_we && !p_we))
        chk("mon_cs_leads_strobe", {31'b0, p_cs}, 32'd1);
      if (sram_oe || sram_we)
        chk("mon_strobe_needs_cs", {31'b0, sram_cs}, 32'd1);
      if (sram_oe && sram_we)
        chk("mon_oe_we_exclusive", 32'd1, {31'b0, resp_valid & 1'b0});
      p_cs = sram_cs; p_oe = sram_oe; p_we = sram_we; p_addr = sram_addr; p_din = sram_din;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat;
    int seen;
    logic busy_bad;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, LAT};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, LAT};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 1'b0, LAT};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, LAT};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, LAT};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, LAT};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, LAT};
    vecs[7] = '{1'b0, 32'h0000_0013, 32'h0000_0000, V7_RD,         MIS_ERR, MIS_LAT};
    vecs[8] = '{1'b1, 32'h0000_0011, 32'h0000_0055, 32'h0000_0000, MIS_ERR, MIS_LAT};
    vecs[9] = '{1'b0, 32'h0000_0010, 32'h0000_0000, V9_RD,         MIS_ERR == 1'b1 ? 1'b0 : 1'b0, LAT};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    step(); step();
    // reset values
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_strobes", {29'b0, sram_cs, sram_oe, sram_we}, 32'd0);
    chk("rst_addr", sram_addr, 32'h0);
    chk("rst_din", sram_din, 32'h0);

    // reset and req_valid together: request must not be accepted
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0200;
    step();
    chk("rst_vs_valid_cs", {31'b0, sram_cs}, 32'd0);
    chk("rst_vs_valid_ready", {31'b0, req_ready}, 32'd1);
    reset = 1'b0; req_valid = 1'b0;
    step();
    chk("post_rst_cs", {31'b0, sram_cs}, 32'd0);
    chk("post_rst_addr", sram_addr, 32'h0);

    // preload and clear the random region through the backdoor
    bd_write(32'h0000_0020, 32'h1234_5678);
    for (int i = 0; i < 16; i++) begin
      bd_write(32'h0000_0100 + 32'(i * 4), 32'h0);
      ref_mem[(32'h0000_0100 + 32'(i * 4)) >> 2] = 32'h0;
    end

    // directed table
    for (int i = 0; i < 10; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);

    // busy backpressure: two requests queued behind a held req_valid
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0140; req_wdata = 32'hA5A5_5A5A;
    chk("bp_ready_first", {31'b0, req_ready}, 32'd1);
    step();
    req_we = 1'b0;
    lat = 1; busy_bad = 1'b0;
    while (!resp_valid && lat < 40) begin
      if (req_ready) busy_bad = 1'b1;
      step(); lat++;
    end
    chk("bp_first_latency", lat, LAT);
    chk("bp_ready_low", {31'b0, busy_bad | req_ready}, 32'd0);
    step();
    chk("bp_ready_after_done", {31'b0, req_ready}, 32'd1);
    step();
    chk("bp_second_accepted", {31'b0, sram_cs}, 32'd1);
    chk("bp_second_ready_low", {31'b0, req_ready}, 32'd0);
    chk("bp_second_addr", sram_addr, 32'h0000_0140);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin step(); lat++; end
    chk("bp_second_latency", lat, LAT);
    chk("bp_second_rdata", resp_rdata, 32'hA5A5_5A5A);
    step();

    // reset in the middle of a write access
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0400; req_wdata = 32'h1111_2222;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_rst_in_access", {31'b0, sram_we}, 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_strobes", {29'b0, sram_cs, sram_oe, sram_we}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen += int'(resp_valid) + int'(sram_cs);
    end
    chk("mid_rst_no_resp", seen, 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      logic        r_we;
      logic [31:0] r_addr, r_data;
      r_we   = 1'($urandom_range(0, 1));
      r_addr = 32'h0000_0100 + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) r_addr = r_addr + 32'($urandom_range(1, 3));
      r_data = $urandom;
      model(r_we, r_addr, r_data, e_rd, e_err, e_lat);
      do_txn($sformatf("rnd%0d", i), r_we, r_addr, r_data, e_rd, e_err, e_lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
